imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate-generation stage for the ID->EX boundary of the pipelined MIPS core.
- Extends plain zero/sign/lui extension with branch-offset and branch-target modes, and adds illegal-mode flagging.
- Output sits behind a 2-entry skid buffer with valid/ready handshake, so back-pressure from EX never drops an immediate.
- Supports pipeline flush.

Parameters:
- DATA_W, 32, output/PC width; must be >= IMM_W+2.
- IMM_W, 16, raw immediate field width.
- PC_INC, 4, PC increment used by the branch-target mode.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream presents an instruction immediate.
- in_ready  out  1  stage can accept this cycle.
- mode  in  3  0 zero-ext, 1 sign-ext, 2 lui, 3 branch offset, 4 branch target, 5-7 illegal.
- imm  in  IMM_W  raw immediate field.
- pc  in  DATA_W  PC of the instruction; used by mode 4 only.
- out_valid  out  1  imm_out holds a valid result.
- out_ready  in  1  downstream accepts the result this cycle.
- imm_out  out  DATA_W  processed immediate.
- mode_err  out  1  qualifies imm_out: entry was produced from an illegal mode.

Behaviour:
- Arithmetic, where S = sign extension of imm to DATA_W and Z = zero extension:
  - mode 0: Z.
  - mode 1: S.
  - mode 2: {imm, (DATA_W-IMM_W) zeros}.
  - mode 3: S << 2, truncated to DATA_W.
  - mode 4: pc + PC_INC + (S << 2), modulo 2^DATA_W; wrap-around is silent.
  - modes 5-7: result 0, err bit 1.
- Result and err bit are computed combinationally from the inputs and captured on acceptance (in_valid & in_ready).
- Storage: main entry (M) drives the outputs; skid entry (K) holds overflow. Each entry holds {valid, data, err}.
- in_ready = ~K.valid & ~reset.
- Latency: an accepted input appears on imm_out/out_valid the next cycle when M is empty or draining.
- Handshake: transfer occurs when out_valid & out_ready.
  - out_valid = M.valid.
  - imm_out and mode_err hold stable while out_valid & ~out_ready.
- Per-edge update:
  - (a) M transfers and K valid: M <- K, K cleared; the input cannot be accepted that cycle since in_ready=0.
  - (b) M transfers and K empty: M <- accepted input if any, else M.valid <- 0.
  - (c) M valid and not transferring: an accepted input goes to K.
  - (d) M empty: an accepted input goes to M.
- Ordering is strictly FIFO; no entry is duplicated or lost.
- Full: K valid, so in_ready=0; upstream must stall.
- Empty: out_valid=0; imm_out and mode_err keep their last value (don't-care to consumers).
- flush: clears M.valid and K.valid at the edge. An input presented in the same cycle is discarded. A transfer in the same cycle still counts as completed by the consumer. flush has priority over acceptance.
- reset: M.valid=K.valid=0, imm_out=0, mode_err=0; in_ready=0 while reset is high and 1 the cycle after. Reset mid-operation discards all entries. reset has priority over flush.

Optional Feature:
- IMM_GEN_ERRCNT_EN defined:
  - Adds output port err_count [7:0].
  - err_count increments by 1 each time an illegal-mode input is accepted (and not flushed in the same cycle).
  - Saturates at 255; cleared by reset only, not by flush.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Extension modes (out_ready=1): mode0 imm=16'h8001 -> imm_out=32'h00008001; mode1 same imm -> 32'hFFFF8001; mode2 imm=16'h1234 -> 32'h12340000. Each appears one cycle after acceptance.
- Branch modes: mode3 imm=16'hFFFF -> 32'hFFFFFFFC. mode4 pc=32'h00400010, imm=16'h0003 -> 32'h00400020. mode4 pc=32'hFFFFFFFC, imm=16'h0001 -> 32'h00000004 (wrap-around).
- Back-pressure: out_ready=0, send A=1, B=2 in consecutive cycles -> after B in_ready=0, imm_out holds 1. Raise out_ready -> 1 then 2 transferred, no loss or duplication, in_ready returns to 1.
- Illegal mode: mode=6 imm=16'hABCD -> imm_out=0, mode_err=1. With IMM_GEN_ERRCNT_EN, 300 illegal inputs -> err_count=255.
- Flush: buffer full (M=1, K=2) and new input 3 in the flush cycle -> next cycle out_valid=0, in_ready=1; 3 never emerges.
- Reset mid-stream: full buffer, assert reset one cycle -> out_valid=0, imm_out=0, in_ready=0 during reset and 1 the cycle after.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the ID->EX boundary, output behind a 2-entry skid buffer.
// Optional illegal-mode counter (err_count) enabled with `define IMM_GEN_ERRCNT_EN.
module imm_gen_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int PC_INC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              mode_err
`ifdef IMM_GEN_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  typedef enum logic [2:0] {
    MODE_ZEXT   = 3'd0,
    MODE_SEXT   = 3'd1,
    MODE_LUI    = 3'd2,
    MODE_BOFF   = 3'd3,
    MODE_BTGT   = 3'd4
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              err;
  } entry_t;

  entry_t m_q, k_q, new_e;

  logic [DATA_W-1:0] zext, sext, boff;
  logic              accept, xfer;

  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign boff = sext << 2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    new_e = '{valid: 1'b1, data: '0, err: 1'b0};
    case (mode)
      MODE_ZEXT: new_e.data = zext;
      MODE_SEXT: new_e.data = sext;
      MODE_LUI:  new_e.data = {imm, {(DATA_W-IMM_W){1'b0}}};
      MODE_BOFF: new_e.data = boff;
      MODE_BTGT: new_e.data = pc + DATA_W'(PC_INC) + boff;
      default:   new_e.err  = 1'b1;
    endcase
  end

  assign in_ready  = ~k_q.valid & ~reset;
  assign out_valid = m_q.valid;
  assign imm_out   = m_q.data;
  assign mode_err  = m_q.err;

  // flush wins over acceptance, so a flushed input never reaches either entry
  assign accept = in_valid & in_ready & ~flush;
  assign xfer   = m_q.valid & out_ready;

  // NOTE: state registers use non-blocking assignments so all entries update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      k_q <= '0;
    end else if (flush) begin
      m_q.valid <= 1'b0;
      k_q.valid <= 1'b0;
    end else if (xfer) begin
      if (k_q.valid) begin
        m_q       <= k_q;
        k_q.valid <= 1'b0;
      end else if (accept) begin
        m_q <= new_e;
      end else begin
        m_q.valid <= 1'b0;
      end
    end else if (m_q.valid) begin
      if (accept) k_q <= new_e;
    end else if (accept) begin
      m_q <= new_e;
    end
  end

`ifdef IMM_GEN_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if (accept && new_e.err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed test-plan cases plus a random handshake phase.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, mode_err;
  logic [2:0]  mode;
  logic [15:0] imm;
  logic [31:0] pc, imm_out;
`ifdef IMM_GEN_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   err_model = 0;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .mode_err(mode_err)
`ifdef IMM_GEN_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [2:0] m, input logic [15:0] i, input logic [31:0] p);
    logic [31:0] s;
    exp_t e;
    s = {{16{i[15]}}, i};
    e = '{data: 32'h0, err: 1'b0};
    case (m)
      3'd0: e.data = {16'h0, i};
      3'd1: e.data = s;
      3'd2: e.data = {i, 16'h0};
      3'd3: e.data = {s[29:0], 2'b00};
      3'd4: e.data = p + 32'd4 + {s[29:0], 2'b00};
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: occupancy of the queue is the expected buffer fill level.
  always @(negedge clk) begin
    if (reset) begin
      check("in_ready_in_reset", in_ready, 0);
      q.delete();
      err_model = 0;
    end else begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < 2);
`ifdef IMM_GEN_ERRCNT_EN
      check("err_count", err_count, err_model);
`endif
      if (out_valid && q.size() != 0) begin
        check("imm_out", imm_out, q[0].data);
        check("mode_err", mode_err, q[0].err);
        if (out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back(model(mode, imm, pc));
        if (mode >= 3'd5 && err_model != 255) err_model++;
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] i,
                       input logic [31:0] p, input logic rdy, input logic fl, input logic rst);
    @(posedge clk);
    #1;
    in_valid = v; mode = m; imm = i; pc = p;
    out_ready = rdy; flush = fl; reset = rst;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 3'd0, 16'h0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  // One accepted input, then a directed check one cycle later.
  task automatic send_check(input string tag, input logic [2:0] m, input logic [15:0] i,
                            input logic [31:0] p, input logic [31:0] exp, input logic exp_err);
    drive(1'b1, m, i, p, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, imm_out, exp);
    check({tag, "_err"}, mode_err, exp_err);
  endtask

  task automatic fill_two();
    drive(1'b1, 3'd0, 16'd1, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 16'd2, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = 3'd0; imm = 16'h0; pc = 32'h0;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_imm_out", imm_out, 32'h0);
    check("rst_mode_err", mode_err, 0);
    check("rst_in_ready", in_ready, 1);

    send_check("zext", 3'd0, 16'h8001, 32'h0, 32'h00008001, 1'b0);
    send_check("sext", 3'd1, 16'h8001, 32'h0, 32'hFFFF8001, 1'b0);
    send_check("lui",  3'd2, 16'h1234, 32'h0, 32'h12340000, 1'b0);
    send_check("boff", 3'd3, 16'hFFFF, 32'h0, 32'hFFFFFFFC, 1'b0);
    send_check("btgt", 3'd4, 16'h0003, 32'h00400010, 32'h00400020, 1'b0);
    send_check("btgt_wrap", 3'd4, 16'h0001, 32'hFFFFFFFC, 32'h00000004, 1'b0);
    send_check("illegal", 3'd6, 16'hABCD, 32'h0, 32'h00000000, 1'b1);

    // back-pressure: two entries held, then drained in order
    fill_two();
    idle(1'b0);
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_hold", imm_out, 32'd1);
    idle(1'b1);
    @(negedge clk);
    check("bp_first", imm_out, 32'd1);
    idle(1'b1);
    @(negedge clk);
    check("bp_second", imm_out, 32'd2);
    check("bp_in_ready_back", in_ready, 1);
    idle(1'b1);
    @(negedge clk);
    check("bp_empty", out_valid, 0);

    // flush with a full buffer and a new input in the same cycle
    fill_two();
    drive(1'b1, 3'd0, 16'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    repeat (3) idle(1'b1);
    @(negedge clk);
    check("flush_no_ghost", out_valid, 0);

    // reset mid-stream
    fill_two();
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    idle(1'b1);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_imm_out", imm_out, 32'h0);
    check("midrst_in_ready_after", in_ready, 1);

    // random handshake traffic, checked by the scoreboard
    for (int n = 0; n < 300; n++)
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 1'b0);
    repeat (3) idle(1'b1);

    // saturation of the illegal-mode counter
    for (int n = 0; n < 300; n++)
      drive(1'b1, 3'($urandom_range(5, 7)), 16'($urandom), 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk);
    check("illegal_stream_err", mode_err, 1);
`ifdef IMM_GEN_ERRCNT_EN
    check("err_count_sat", err_count, 32'd255);
`endif
    idle(1'b1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
